// File: rtl/gray_display_pkg.sv
// gray_display_pkg: shared types and helpers for the Gray-code switch display.
package gray_display_pkg;

    typedef enum logic {UNITS, TENS} digit_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low segments ordered g..a.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'b1000000;
            4'd1:    seg_encode = 7'b1111001;
            4'd2:    seg_encode = 7'b0100100;
            4'd3:    seg_encode = 7'b0110000;
            4'd4:    seg_encode = 7'b0011001;
            4'd5:    seg_encode = 7'b0010010;
            4'd6:    seg_encode = 7'b0000010;
            4'd7:    seg_encode = 7'b1111000;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0010000;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        gray2bin = {g[3], ^g[3:2], ^g[3:1], ^g[3:0]};
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes the switch bus and commits a Gray word once it has been stable.
module switch_debouncer
    import gray_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk_pi,
    input  logic       rst_n_pi,
    input  logic [3:0] codigo_gray_pi,
    output logic [3:0] codigo_bin_po,
    output logic       cambio_po
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, cand_q, cand_d, com_q, com_d, bin_q, bin_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic cambio_q, cambio_d;

    // The counter saturates, so a settled candidate equal to the committed word never re-fires.
    always_comb begin
        sync1_d  = codigo_gray_pi;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        com_d    = com_q;
        bin_d    = bin_q;
        cambio_d = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
            if (cand_q != com_q) begin
                com_d    = cand_q;
                bin_d    = gray2bin(cand_q);
                cambio_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_pi) begin
        if (!rst_n_pi) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            com_q    <= '0;
            bin_q    <= '0;
            cambio_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            com_q    <= com_d;
            bin_q    <= bin_d;
            cambio_q <= cambio_d;
        end
    end

    assign codigo_bin_po = bin_q;
    assign cambio_po     = cambio_q;

endmodule

// File: rtl/gray_display_controller.sv
// gray_display_controller: debounced Gray switches to binary LEDs and a 2-digit multiplexed decimal display.
module gray_display_controller
    import gray_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int REFRESH_CYCLES  = 27000
) (
    input  logic       clk_pi,
    input  logic       rst_n_pi,
    input  logic [3:0] codigo_gray_pi,
    output logic [3:0] codigo_bin_led_po,
    output logic       cambio_po,
    output logic [6:0] seg_po,
    output logic [1:0] anodo_po
);

    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    logic [3:0] bin, units;
    logic tens, wrap;
    logic [RW-1:0] ref_q, ref_d;
    digit_state_t state_q, state_d;
    logic [6:0] seg_q, seg_d;
    logic [1:0] anodo_q, anodo_d;

    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clk_pi         (clk_pi),
        .rst_n_pi       (rst_n_pi),
        .codigo_gray_pi (codigo_gray_pi),
        .codigo_bin_po  (bin),
        .cambio_po      (cambio_po)
    );

    // Segments and anode are both derived from the next state so they switch on the same edge.
    always_comb begin
        wrap    = ref_q == REF_LAST;
        ref_d   = wrap ? '0 : ref_q + RW'(1);
        state_d = wrap ? (state_q == UNITS ? TENS : UNITS) : state_q;
        tens    = bin >= 4'd10;
        units   = tens ? bin - 4'd10 : bin;
        seg_d   = state_d == UNITS ? seg_encode(units) : (tens ? seg_encode(4'd1) : SEG_BLANK);
        anodo_d = state_d == UNITS ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk_pi) begin
        if (!rst_n_pi) begin
            ref_q   <= '0;
            state_q <= UNITS;
            seg_q   <= 7'b1000000;
            anodo_q <= 2'b10;
        end else begin
            ref_q   <= ref_d;
            state_q <= state_d;
            seg_q   <= seg_d;
            anodo_q <= anodo_d;
        end
    end

    assign codigo_bin_led_po = bin;
    assign seg_po            = seg_q;
    assign anodo_po          = anodo_q;

endmodule

// File: doc/gray_display_controller.md
Name: gray_display_controller

Overview:
Sequencer around the Gray-to-binary datapath for the board's 4-bit DIP switch input. It synchronizes and debounces the switch bus, then commits a stable Gray word and converts it to binary for the LEDs. It also schedules a 2-digit multiplexed 7-segment display showing the binary value in decimal (0–15). It sits between the switch pins and the LED and segment pins.

Parameters:
DEBOUNCE_CYCLES, 270000, consecutive stable clocks required before commit (10 ms at 27 MHz); legal values 2 and up.
REFRESH_CYCLES, 27000, clocks each digit stays enabled (1 ms at 27 MHz); legal values 2 and up.

Ports:
clk_pi  in  1  system clock
rst_n_pi  in  1  reset, synchronous, active-low
codigo_gray_pi  in  4  raw asynchronous Gray code from switches
codigo_bin_led_po  out  4  committed binary value to LEDs
cambio_po  out  1  one-cycle pulse when a new value is committed
seg_po  out  7  segments, active-low; bit0=a … bit6=g
anodo_po  out  2  digit enables, active-low; bit0=units, bit1=tens

Behaviour:
- Clock and reset: one clock, clk_pi. Reset rst_n_pi is synchronous and active-low, sampled on the rising edge. Reset asserted mid-operation aborts debounce and display scheduling immediately.
- Reset values:
  - codigo_bin_led_po=0, cambio_po=0.
  - Sync flops, candidate and committed Gray all 0; debounce and refresh counters 0.
  - FSM in UNITS; anodo_po=2'b10; seg_po=7'b1000000 (digit 0).
- Synchronizer: 2-flop on all 4 bits (sync1, sync2).
- Debounce, evaluated every clock:
  - If sync2 != candidate: candidate<=sync2, cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: if candidate != committed, then committed<=candidate, codigo_bin_led_po<=gray2bin(candidate), cambio_po<=1 for one cycle. cnt holds (saturates).
  - Else cnt<=cnt+1.
- Debounce timing:
  - A pin change before edge 1 is committed at edge DEBOUNCE_CYCLES+3 if the pins stay stable.
  - Any change during the window restarts the count.
  - Returning to the already-committed value produces no pulse and no output change.
- gray2bin: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0. Purely combinational.
- Digit split: tens = (bin>=10), units = bin-10*tens. Use a compare-and-subtract; no divider.
- Display FSM states:
  - UNITS: anodo_po=2'b10, seg_po=enc(units).
  - TENS: anodo_po=2'b01, seg_po=enc(1) if tens, else 7'b1111111 (leading-zero blank; the anode is still driven).
- Display transitions:
  - The refresh counter counts 0..REFRESH_CYCLES-1 and wraps.
  - On wrap the FSM toggles UNITS<->TENS.
  - seg_po and anodo_po are registered and change on the same edge, so there is no ghosting cycle.
  - A commit takes effect in seg_po on the next edge after commit and does not reset the refresh phase.
- Simultaneous events: a commit landing on a refresh wrap is legal. The new value goes to the newly selected digit one edge later.
- enc() table, active-low, g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

Decomposition:
- Package gray_display_pkg:
  - typedef enum logic {UNITS, TENS} digit_state_t
  - localparam SEG_BLANK=7'b1111111
  - function seg_encode(logic [3:0]) returning logic [6:0]
  - function gray2bin(logic [3:0]) returning logic [3:0]
- One natural sub-module: switch_debouncer. It holds the synchronizer, candidate, counter and commit/pulse logic, and is parameterized by DEBOUNCE_CYCLES.
- Display scheduling stays in the top module.

Test Plan:
Use DEBOUNCE_CYCLES=8 and REFRESH_CYCLES=4 for all scenarios.
1. Reset: hold rst_n_pi=0 for 3 clocks -> codigo_bin_led_po=0, cambio_po=0, anodo_po=2'b10, seg_po=7'b1000000. Then release -> anodo_po toggles every 4 clocks.
2. Stable input: drive codigo_gray_pi=4'b1000 and hold -> at edge 11, codigo_bin_led_po=4'b1111 and cambio_po=1 for exactly 1 clock. Display then shows units seg 0010010 (5) and tens seg 1111001 (1).
3. Bounce rejection: drive 4'b0010 for 5 clocks, then 4'b0000 -> no cambio_po pulse, output stays 0.
4. Bounce then settle: drive 4'b0010 for 5 clocks, then hold it stable -> commits bin 4'b0011 exactly 11 clocks after it settles. Tens digit is blank (1111111), units is 0110000 (3).
5. Repeat value: commit 4'b1000, glitch to 4'b1001 for 3 clocks, return to 4'b1000 -> no further cambio_po pulse, output unchanged.
6. Reset mid-operation: assert rst_n_pi during debounce count 5 and during the TENS phase -> all outputs equal the reset values on the next edge. After release, a full DEBOUNCE_CYCLES+3 window is required to commit again.
